// File: rtl/emif_arb_pkg.sv
// rtl/emif_arb_pkg.sv - shared types for the two-port EMIF Avalon-MM arbiter
package emif_arb_pkg;

  localparam int PORT_W   = 1;
  localparam int TAG_BC_W = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_CMD   = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  // One entry per outstanding read command: who issued it and how many beats return
  typedef struct packed {
    logic [PORT_W-1:0]   port;
    logic [TAG_BC_W-1:0] burstcount;
  } rd_tag_t;

endpackage

// File: rtl/emif_rd_tag_fifo.sv
// rtl/emif_rd_tag_fifo.sv - synchronous FIFO of outstanding read tags
module emif_rd_tag_fifo
  import emif_arb_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  rd_tag_t       push_tag,
  input  logic          pop,
  output rd_tag_t       head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  rd_tag_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Tag storage; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  // Pointers and fill level; a simultaneous push and pop leaves the level unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/emif_amm_arbiter.sv
// rtl/emif_amm_arbiter.sv - round-robin two-port arbiter for the EMIF Avalon-MM user port
module emif_amm_arbiter
  import emif_arb_pkg::*;
#(
  parameter int ADDR_W       = 27,
  parameter int DATA_W       = 128,
  parameter int BE_W         = 16,
  parameter int BURST_W      = 7,
  parameter int RD_TAG_DEPTH = 32,
  localparam int LVL_W = $clog2(RD_TAG_DEPTH) + 1
) (
  input  logic                 emif_usr_clk,
  input  logic                 emif_usr_reset,
  input  logic                 local_cal_success,
  input  logic [1:0]           s_read,
  input  logic [1:0]           s_write,
  input  logic [2*ADDR_W-1:0]  s_address,
  input  logic [2*DATA_W-1:0]  s_writedata,
  input  logic [2*BE_W-1:0]    s_byteenable,
  input  logic [2*BURST_W-1:0] s_burstcount,
  output logic [1:0]           s_ready,
  output logic [DATA_W-1:0]    s_readdata,
  output logic [1:0]           s_readdatavalid,
  input  logic                 amm_ready,
  output logic                 amm_read,
  output logic                 amm_write,
  output logic [ADDR_W-1:0]    amm_address,
  output logic [DATA_W-1:0]    amm_writedata,
  output logic [BE_W-1:0]      amm_byteenable,
  output logic [BURST_W-1:0]   amm_burstcount,
  input  logic [DATA_W-1:0]    amm_readdata,
  input  logic                 amm_readdatavalid,
  output logic [LVL_W-1:0]     rd_outstanding,
  output logic                 protocol_err
);

  state_t               state, state_nx;
  logic                 g, g_nx, last, last_nx;
  logic [BURST_W-1:0]   wr_cnt, wr_cnt_nx, wr_len, wr_len_nx, cur_len;
  logic [BURST_W-1:0]   rd_cnt, bc_g, bc_eff;
  logic [1:0]           req;
  logic                 busy, push, pop, err_set, rv_ok;
  logic                 fifo_full, fifo_empty;
  rd_tag_t              push_tag, head;

  assign busy   = (state != IDLE);
  assign req    = (s_read | s_write) & {2{local_cal_success}};
  assign bc_g   = g ? s_burstcount[BURST_W +: BURST_W] : s_burstcount[0 +: BURST_W];
  // A zero burstcount is flagged but still forwarded and tracked as a single beat
  assign bc_eff = (bc_g == '0) ? BURST_W'(1) : bc_g;

  assign amm_address    = busy ? (g ? s_address[ADDR_W +: ADDR_W] : s_address[0 +: ADDR_W]) : '0;
  assign amm_writedata  = busy ? (g ? s_writedata[DATA_W +: DATA_W] : s_writedata[0 +: DATA_W]) : '0;
  assign amm_byteenable = busy ? (g ? s_byteenable[BE_W +: BE_W] : s_byteenable[0 +: BE_W]) : '0;
  assign amm_burstcount = busy ? bc_g : '0;

  assign push_tag = '{port: g, burstcount: bc_eff};

  // Return path: route each beat to the port at the FIFO head; stray beats are dropped
  assign s_readdata      = amm_readdata;
  assign rv_ok           = amm_readdatavalid & ~fifo_empty;
  assign s_readdatavalid = rv_ok ? (head.port[0] ? 2'b10 : 2'b01) : 2'b00;
  assign pop             = rv_ok & ((rd_cnt + 1'b1) == head.burstcount);

  emif_rd_tag_fifo #(.DEPTH(RD_TAG_DEPTH)) u_tag_fifo (
    .clk      (emif_usr_clk),
    .rst      (emif_usr_reset),
    .push     (push),
    .push_tag (push_tag),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (rd_outstanding)
  );

  // Arbitration, command forwarding and burst tracking
  always_comb begin
    state_nx  = state;
    g_nx      = g;
    last_nx   = last;
    wr_cnt_nx = wr_cnt;
    wr_len_nx = wr_len;
    cur_len   = wr_len;
    amm_read  = 1'b0;
    amm_write = 1'b0;
    s_ready   = 2'b00;
    push      = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          g_nx     = (req == 2'b11) ? ~last : req[1];
          state_nx = s_write[g_nx] ? WR_BURST : RD_CMD;
          err_set  = s_read[g_nx] & s_write[g_nx];
        end
      end
      RD_CMD: begin
        amm_read   = s_read[g] & ~fifo_full;
        s_ready[g] = amm_ready & ~fifo_full;
        if (amm_read && amm_ready) begin
          push     = 1'b1;
          err_set  = (bc_g == '0);
          last_nx  = g;
          state_nx = IDLE;
        end
      end
      WR_BURST: begin
        amm_write  = s_write[g];
        s_ready[g] = amm_ready;
        if (amm_write && amm_ready) begin
          if (wr_cnt == '0) begin
            cur_len   = bc_eff;
            wr_len_nx = bc_eff;
            err_set   = (bc_g == '0);
          end
          if ((wr_cnt + 1'b1) == cur_len) begin
            wr_cnt_nx = '0;
            last_nx   = g;
            state_nx  = IDLE;
          end else begin
            wr_cnt_nx = wr_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, grant and counter registers plus the sticky error flag
  always_ff @(posedge emif_usr_clk or posedge emif_usr_reset) begin
    if (emif_usr_reset) begin
      state        <= IDLE;
      g            <= 1'b0;
      last         <= 1'b1;
      wr_cnt       <= '0;
      wr_len       <= '0;
      rd_cnt       <= '0;
      protocol_err <= 1'b0;
    end else begin
      state  <= state_nx;
      g      <= g_nx;
      last   <= last_nx;
      wr_cnt <= wr_cnt_nx;
      wr_len <= wr_len_nx;
      if (pop)        rd_cnt <= '0;
      else if (rv_ok) rd_cnt <= rd_cnt + 1'b1;
      if (err_set || (amm_readdatavalid && fifo_empty)) protocol_err <= 1'b1;
    end
  end

endmodule
